output_write_sequencer: RTL and testbench

//  Sequences write-back of one conv layer's output volume after the output parameters are latched.

---
 rtl/output_write_sequencer_if.sv | 39 +++
 rtl/output_write_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_output_write_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_write_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : output_write_sequencer_if
// Brief    : Write-request / ack handshake between the output write sequencer
//            and the output DMA.
// Revision : 1.0 - initial release
// ============================================================================
interface output_write_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int W_W    = 12
) ();

  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [W_W-1:0]    wr_req_len;
  logic              wr_req_last;
  logic              wr_ack;

  modport master (
    output wr_req_valid,
    output wr_req_addr,
    output wr_req_len,
    output wr_req_last,
    input  wr_req_ready,
    input  wr_ack
  );

  modport slave (
    input  wr_req_valid,
    input  wr_req_addr,
    input  wr_req_len,
    input  wr_req_last,
    output wr_req_ready,
    output wr_ack
  );

endinterface
`default_nettype wire

// File: rtl/output_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : output_write_sequencer
// Brief    : Walks channel groups, rows (optionally doubled) and burst segments
//            of one output volume, issuing one DMA write request per segment.
// Revision : 1.0 - initial release
// ============================================================================
module output_write_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int CG_W      = 6,
  parameter int H_W       = 10,
  parameter int W_W       = 12,
  parameter int GAP_W     = 20,
  parameter int FRM_W     = 24,
  parameter int BURST_MAX = 16,
  parameter int MAX_OUT   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     set_out_params,
  input  logic [ADDR_W-1:0]        cfg_frame_start,
  input  logic [FRM_W-1:0]         cfg_frame_size,
  input  logic [GAP_W-1:0]         cfg_addr_gap,
  input  logic [W_W-1:0]           cfg_out_w,
  input  logic [H_W-1:0]           cfg_rows_m1,
  input  logic [CG_W-1:0]          cfg_idx_max,
  input  logic                     cfg_upsample,
  output_write_sequencer_if.master wrBus,
  output logic                     busy,
  output logic                     reset_isOnOutput,
  output logic                     start_dropped
);

  localparam int c_OUT_W = $clog2(MAX_OUT + 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [W_W-1:0]     c_BURST   = W_W'(BURST_MAX);
  localparam logic [c_OUT_W-1:0] c_MAX_OUT = c_OUT_W'(MAX_OUT);
  localparam logic [c_OUT_W-1:0] c_OUT_ONE = c_OUT_W'(1);

  // --------------------------------------------------------------------------
  // State and latched job configuration
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [FRM_W-1:0]   r_frameSize;
  logic [GAP_W-1:0]   r_addrGap;
  logic [W_W-1:0]     r_outW;
  logic [H_W-1:0]     r_rowsM1;
  logic [CG_W-1:0]    r_idxMax;
  logic               r_upsample;

  logic [W_W-1:0]     r_col;
  logic               r_copy;
  logic [H_W-1:0]     r_row;
  logic [CG_W-1:0]    r_grp;
  logic [ADDR_W-1:0]  r_rowAddr;
  logic [ADDR_W-1:0]  r_grpBase;
  logic [c_OUT_W-1:0] r_outstanding;
  logic               r_done;
  logic               r_dropped;

  // --------------------------------------------------------------------------
  // Combinational request generation
  // --------------------------------------------------------------------------
  logic               w_issue;
  logic               w_valid;
  logic               w_xfer;
  logic               w_ackTaken;
  logic [W_W-1:0]     w_remain;
  logic [W_W-1:0]     w_len;
  logic               w_rowDone;
  logic               w_lastCopy;
  logic               w_lastRow;
  logic               w_lastGrp;
  logic               w_last;
  logic [ADDR_W-1:0]  w_gapExt;
  logic [ADDR_W-1:0]  w_nextGrpBase;
  logic [c_OUT_W-1:0] w_outNext;

  assign w_issue    = (r_state == c_ISSUE);
  assign w_valid    = w_issue && (r_outstanding < c_MAX_OUT);
  assign w_xfer     = w_valid && wrBus.wr_req_ready;
  assign w_ackTaken = wrBus.wr_ack && (r_outstanding != '0);

  assign w_remain   = r_outW - r_col;
  assign w_rowDone  = (w_remain <= c_BURST);
  assign w_len      = w_rowDone ? w_remain : c_BURST;

  assign w_lastCopy = !r_upsample || r_copy;
  assign w_lastRow  = (r_row == r_rowsM1);
  assign w_lastGrp  = (r_grp == r_idxMax);
  assign w_last     = w_rowDone && w_lastCopy && w_lastRow && w_lastGrp;

  assign w_gapExt      = ADDR_W'(r_addrGap);
  assign w_nextGrpBase = r_grpBase + ADDR_W'(r_frameSize);

  // Transfer and ack in the same cycle cancel out; acks with nothing in flight are dropped.
  always_comb begin
    w_outNext = r_outstanding;
    if (w_xfer && !w_ackTaken) begin
      w_outNext = r_outstanding + c_OUT_ONE;
    end else if (!w_xfer && w_ackTaken) begin
      w_outNext = r_outstanding - c_OUT_ONE;
    end
  end

  // Fields are forced to zero outside ISSUE so idle outputs read as 0.
  assign wrBus.wr_req_valid = w_valid;
  assign wrBus.wr_req_addr  = w_issue ? (r_rowAddr + ADDR_W'(r_col)) : '0;
  assign wrBus.wr_req_len   = w_issue ? w_len : '0;
  assign wrBus.wr_req_last  = w_issue && w_last;

  assign busy             = (r_state != c_IDLE);
  assign reset_isOnOutput = r_done;
  assign start_dropped    = r_dropped;

  // --------------------------------------------------------------------------
  // Sequencing
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= c_IDLE;
      r_frameSize   <= '0;
      r_addrGap     <= '0;
      r_outW        <= '0;
      r_rowsM1      <= '0;
      r_idxMax      <= '0;
      r_upsample    <= 1'b0;
      r_col         <= '0;
      r_copy        <= 1'b0;
      r_row         <= '0;
      r_grp         <= '0;
      r_rowAddr     <= '0;
      r_grpBase     <= '0;
      r_outstanding <= '0;
      r_done        <= 1'b0;
      r_dropped     <= 1'b0;
    end else begin
      r_outstanding <= w_outNext;
      r_dropped     <= set_out_params && (r_state != c_IDLE);
      r_done        <= 1'b0;

      case (r_state)
        c_IDLE: begin
          if (set_out_params) begin
            r_frameSize <= cfg_frame_size;
            r_addrGap   <= cfg_addr_gap;
            r_outW      <= cfg_out_w;
            r_rowsM1    <= cfg_rows_m1;
            r_idxMax    <= cfg_idx_max;
            r_upsample  <= cfg_upsample;
            r_rowAddr   <= cfg_frame_start;
            r_grpBase   <= cfg_frame_start;
            r_col       <= '0;
            r_copy      <= 1'b0;
            r_row       <= '0;
            r_grp       <= '0;
            r_state     <= (cfg_out_w == '0) ? c_DRAIN : c_ISSUE;
          end
        end

        c_ISSUE: begin
          if (w_xfer) begin
            if (w_last) begin
              r_col   <= '0;
              r_copy  <= 1'b0;
              r_row   <= '0;
              r_grp   <= '0;
              r_state <= c_DRAIN;
            end else if (!w_rowDone) begin
              r_col <= r_col + w_len;
            end else begin
              r_col <= '0;
              if (!w_lastCopy) begin
                r_copy    <= 1'b1;
                r_rowAddr <= r_rowAddr + w_gapExt;
              end else begin
                r_copy <= 1'b0;
                if (!w_lastRow) begin
                  r_row     <= r_row + H_W'(1);
                  r_rowAddr <= r_rowAddr + w_gapExt;
                end else begin
                  // Next channel group restarts from its own frame base, not the row stride.
                  r_row     <= '0;
                  r_grp     <= r_grp + CG_W'(1);
                  r_grpBase <= w_nextGrpBase;
                  r_rowAddr <= w_nextGrpBase;
                end
              end
            end
          end
        end

        c_DRAIN: begin
          if (w_outNext == '0) begin
            r_done  <= 1'b1;
            r_state <= c_IDLE;
          end
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_write_sequencer
// Brief    : Directed and randomized jobs checked against a nested-loop model
//            of the expected request stream, ack timing and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_write_sequencer;

  localparam int ADDR_W    = 32;
  localparam int CG_W      = 6;
  localparam int H_W       = 10;
  localparam int W_W       = 12;
  localparam int GAP_W     = 20;
  localparam int FRM_W     = 24;
  localparam int BURST_MAX = 16;
  localparam int MAX_OUT   = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              set_out_params;
  logic [ADDR_W-1:0] cfg_frame_start;
  logic [FRM_W-1:0]  cfg_frame_size;
  logic [GAP_W-1:0]  cfg_addr_gap;
  logic [W_W-1:0]    cfg_out_w;
  logic [H_W-1:0]    cfg_rows_m1;
  logic [CG_W-1:0]   cfg_idx_max;
  logic              cfg_upsample;
  logic              busy;
  logic              reset_isOnOutput;
  logic              start_dropped;

  output_write_sequencer_if #(.ADDR_W(ADDR_W), .W_W(W_W)) wrIf ();

  output_write_sequencer #(
    .ADDR_W(ADDR_W), .CG_W(CG_W), .H_W(H_W), .W_W(W_W), .GAP_W(GAP_W),
    .FRM_W(FRM_W), .BURST_MAX(BURST_MAX), .MAX_OUT(MAX_OUT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .set_out_params   (set_out_params),
    .cfg_frame_start  (cfg_frame_start),
    .cfg_frame_size   (cfg_frame_size),
    .cfg_addr_gap     (cfg_addr_gap),
    .cfg_out_w        (cfg_out_w),
    .cfg_rows_m1      (cfg_rows_m1),
    .cfg_idx_max      (cfg_idx_max),
    .cfg_upsample     (cfg_upsample),
    .wrBus            (wrIf),
    .busy             (busy),
    .reset_isOnOutput (reset_isOnOutput),
    .start_dropped    (start_dropped)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [11:0] len;
    logic        last;
  } req_t;

  req_t        expQ[$];
  logic [31:0] obsAddr[$];
  logic [11:0] obsLen[$];
  logic        obsLast[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] jBase;
  logic [23:0] jFrame;
  logic [19:0] jGap;
  logic [11:0] jOutW;
  logic [9:0]  jRowsM1;
  logic [5:0]  jIdxMax;
  logic        jUps;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected request stream: every group, row and copy is a row base plus burst offsets.
  function automatic void build_expected();
    int copies;
    copies = jUps ? 2 : 1;
    expQ.delete();
    for (int g = 0; g <= int'(jIdxMax); g++) begin
      for (int r = 0; r <= int'(jRowsM1); r++) begin
        for (int c = 0; c < copies; c++) begin
          logic [31:0] rowBase;
          rowBase = jBase + 32'(g) * 32'(jFrame) + 32'(r * copies + c) * 32'(jGap);
          for (int col = 0; col < int'(jOutW); col += BURST_MAX) begin
            req_t q;
            q.addr = rowBase + 32'(col);
            q.len  = 12'((int'(jOutW) - col < BURST_MAX) ? (int'(jOutW) - col) : BURST_MAX);
            q.last = (g == int'(jIdxMax)) && (r == int'(jRowsM1)) && (c == copies - 1) &&
                     (col + BURST_MAX >= int'(jOutW));
            expQ.push_back(q);
          end
        end
      end
    end
  endfunction

  task automatic run_job(input int readyPct, input int ackMin, input int ackMax, input int stallN,
                         input int dropAt, input int rstAt, output int nXfer);
    int          inflight;
    int          ackDue[$];
    int          lastDue;
    int          due;
    bit          doneDue;
    bit          finished;
    bit          ackNow;
    bit          stalled;
    logic [31:0] pAddr;
    logic [11:0] pLen;
    logic        pLast;
    req_t        e;

    inflight = 0; lastDue = 0; doneDue = 0; finished = 0; stalled = 0; nXfer = 0;
    pAddr = '0; pLen = '0; pLast = 1'b0;
    build_expected();
    obsAddr.delete(); obsLen.delete(); obsLast.delete();

    @(posedge clock); #1;
    set_out_params  = 1'b1;
    cfg_frame_start = jBase;
    cfg_frame_size  = jFrame;
    cfg_addr_gap    = jGap;
    cfg_out_w       = jOutW;
    cfg_rows_m1     = jRowsM1;
    cfg_idx_max     = jIdxMax;
    cfg_upsample    = jUps;
    wrIf.wr_req_ready = 1'b0;
    wrIf.wr_ack       = 1'b0;
    @(negedge clock);
    chk("start_valid", wrIf.wr_req_valid, 0);
    chk("start_busy", busy, 0);

    for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
      @(posedge clock); #1;
      set_out_params  = (cyc == dropAt);
      reset           = (cyc == rstAt);
      // Garbage on the config bus once the job is latched.
      cfg_frame_start = $urandom();
      cfg_frame_size  = 24'($urandom());
      cfg_addr_gap    = 20'($urandom());
      cfg_out_w       = 12'($urandom());
      cfg_rows_m1     = 10'($urandom());
      cfg_idx_max     = 6'($urandom());
      cfg_upsample    = 1'($urandom());
      wrIf.wr_req_ready = (cyc > stallN) && ($urandom_range(99) < readyPct);
      ackNow = (ackDue.size() > 0) && (ackDue[0] <= cyc);
      if (ackNow) void'(ackDue.pop_front());
      wrIf.wr_ack = ackNow;
      @(negedge clock);

      if (rstAt > 0 && cyc > rstAt) begin
        chk("rst_valid", wrIf.wr_req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", reset_isOnOutput, 0);
        if (cyc >= rstAt + 6) finished = 1;
      end else begin
        chk("valid", wrIf.wr_req_valid, (expQ.size() > 0) && (inflight < MAX_OUT));
        chk("busy", busy, !doneDue);
        chk("done", reset_isOnOutput, doneDue);
        chk("dropped", start_dropped, (dropAt > 0) && (cyc == dropAt + 1));
        if (stalled) begin
          chk("stall_valid", wrIf.wr_req_valid, 1);
          chk("stall_addr", wrIf.wr_req_addr, pAddr);
          chk("stall_len", wrIf.wr_req_len, pLen);
          chk("stall_last", wrIf.wr_req_last, pLast);
        end
        if (wrIf.wr_req_valid && wrIf.wr_req_ready) begin
          if (expQ.size() == 0) begin
            chk("extra_req", 1, 0);
          end else begin
            e = expQ.pop_front();
            chk("req_addr", wrIf.wr_req_addr, e.addr);
            chk("req_len", wrIf.wr_req_len, e.len);
            chk("req_last", wrIf.wr_req_last, e.last);
          end
          obsAddr.push_back(wrIf.wr_req_addr);
          obsLen.push_back(wrIf.wr_req_len);
          obsLast.push_back(wrIf.wr_req_last);
          nXfer++;
          inflight++;
          due = cyc + int'($urandom_range(ackMax, ackMin));
          if (due <= lastDue) due = lastDue + 1;
          lastDue = due;
          ackDue.push_back(due);
        end
        stalled = wrIf.wr_req_valid && !wrIf.wr_req_ready;
        pAddr = wrIf.wr_req_addr;
        pLen  = wrIf.wr_req_len;
        pLast = wrIf.wr_req_last;
        if (ackNow) inflight--;
        if (doneDue) finished = 1;
        else doneDue = (expQ.size() == 0) && (inflight == 0);
      end
    end
    if (!finished) chk("job_timeout", 0, 1);

    @(posedge clock); #1;
    set_out_params = 1'b0;
    reset = 1'b0;
    wrIf.wr_req_ready = 1'b0;
    wrIf.wr_ack = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; set_out_params = 1'b0;
    cfg_frame_start = '0; cfg_frame_size = '0; cfg_addr_gap = '0; cfg_out_w = '0;
    cfg_rows_m1 = '0; cfg_idx_max = '0; cfg_upsample = 1'b0;
    wrIf.wr_req_ready = 1'b0; wrIf.wr_ack = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst0_valid", wrIf.wr_req_valid, 0);
    chk("rst0_addr", wrIf.wr_req_addr, 0);
    chk("rst0_len", wrIf.wr_req_len, 0);
    chk("rst0_last", wrIf.wr_req_last, 0);
    chk("rst0_busy", busy, 0);
    chk("rst0_done", reset_isOnOutput, 0);
    chk("rst0_dropped", start_dropped, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Basic walk over two groups of two rows
    jBase = 32'h1000; jGap = 20'd64; jFrame = 24'd1024; jOutW = 12'd8;
    jRowsM1 = 10'd1; jIdxMax = 6'd1; jUps = 1'b0;
    run_job(100, 2, 2, 0, -1, -1, n);
    chk("t1_count", n, 4);
    chk("t1_addr1", obsAddr[1], 32'h1040);
    chk("t1_addr2", obsAddr[2], 32'h1400);
    chk("t1_addr3", obsAddr[3], 32'h1440);
    chk("t1_last3", obsLast[3], 1);

    // Burst split of a 40-word row
    jBase = 32'h2000; jGap = 20'd0; jFrame = 24'd0; jOutW = 12'd40;
    jRowsM1 = 10'd0; jIdxMax = 6'd0; jUps = 1'b0;
    run_job(100, 1, 3, 0, -1, -1, n);
    chk("t2_count", n, 3);
    chk("t2_len2", obsLen[2], 8);
    chk("t2_addr2", obsAddr[2], 32'h2020);

    // Upsampled single row
    jBase = 32'h3000; jGap = 20'd64; jFrame = 24'd0; jOutW = 12'd4;
    jRowsM1 = 10'd0; jIdxMax = 6'd0; jUps = 1'b1;
    run_job(100, 1, 2, 0, -1, -1, n);
    chk("t3_count", n, 2);
    chk("t3_addr1", obsAddr[1], 32'h3040);
    chk("t3_last1", obsLast[1], 1);

    // Backpressure then in-flight limit with slow acks
    jBase = 32'h4000; jGap = 20'd32; jFrame = 24'h100; jOutW = 12'd16;
    jRowsM1 = 10'd2; jIdxMax = 6'd1; jUps = 1'b0;
    run_job(100, 30, 30, 5, -1, -1, n);
    chk("t4_count", n, 6);

    // Start while busy is dropped and the job carries on
    jBase = 32'h5000; jGap = 20'd48; jFrame = 24'h200; jOutW = 12'd20;
    jRowsM1 = 10'd1; jIdxMax = 6'd1; jUps = 1'b1;
    run_job(70, 1, 5, 0, 3, -1, n);
    chk("t5_count", n, 16);

    // Reset mid-job abandons the volume
    run_job(80, 3, 6, 0, -1, 8, n);

    // Zero-width volume
    jBase = 32'h6000; jOutW = 12'd0; jRowsM1 = 10'd3; jIdxMax = 6'd2; jUps = 1'b0;
    run_job(100, 1, 1, 0, -1, -1, n);
    chk("t6_count", n, 0);

    // Address wrap
    jBase = 32'hFFFF_FFF0; jGap = 20'd32; jFrame = 24'd0; jOutW = 12'd4;
    jRowsM1 = 10'd1; jIdxMax = 6'd0; jUps = 1'b0;
    run_job(100, 1, 2, 0, -1, -1, n);
    chk("t6_wrap", obsAddr[1], 32'h10);

    for (int k = 0; k < 8; k++) begin
      jBase   = $urandom();
      jGap    = 20'($urandom());
      jFrame  = 24'($urandom());
      jOutW   = 12'($urandom_range(40, 1));
      jRowsM1 = 10'($urandom_range(3, 0));
      jIdxMax = 6'($urandom_range(2, 0));
      jUps    = 1'($urandom());
      run_job(int'($urandom_range(100, 30)), 1, int'($urandom_range(10, 1)), 0, -1, -1, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
